// File: rtl/mips_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_isa_pkg
// Brief    : Opcode/funct encodings, request-op enum and halt word shared by
//            the instruction encoder and the control decoder.
// Revision : 1.0
// ============================================================================
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    // beq $0,$0,-1 : a self-loop that parks the core
    localparam logic [31:0] HALT_WORD = 32'h1000_FFFF;

    typedef enum logic [3:0] {
        REQ_ADD  = 4'd0,
        REQ_SUB  = 4'd1,
        REQ_AND  = 4'd2,
        REQ_OR   = 4'd3,
        REQ_SLT  = 4'd4,
        REQ_LW   = 4'd5,
        REQ_SW   = 4'd6,
        REQ_BEQ  = 4'd7,
        REQ_ADDI = 4'd8
    } req_op_e;

endpackage
`default_nettype wire

// File: rtl/mips_instr_field_pack.sv
`default_nettype none
// ============================================================================
// Module   : mips_instr_field_pack
// Brief    : Combinational packing of a symbolic request into a MIPS word.
// Revision : 1.0
// ============================================================================
module mips_instr_field_pack
    import mips_isa_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [15:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    always_comb begin
        o_word    = '0;
        o_illegal = 1'b0;
        case (req_op_e'(i_op))
            REQ_ADD:  o_word = {OP_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_ADD};
            REQ_SUB:  o_word = {OP_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_SUB};
            REQ_AND:  o_word = {OP_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_AND};
            REQ_OR:   o_word = {OP_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_OR};
            REQ_SLT:  o_word = {OP_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_SLT};
            REQ_LW:   o_word = {OP_LW,   i_rs, i_rt, i_imm};
            REQ_SW:   o_word = {OP_SW,   i_rs, i_rt, i_imm};
            REQ_BEQ:  o_word = {OP_BEQ,  i_rs, i_rt, i_imm};
            REQ_ADDI: o_word = {OP_ADDI, i_rs, i_rt, i_imm};
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : mips_instr_encoder
// Brief    : Encodes symbolic requests into MIPS words and streams them into
//            imem. MIPS_INSTR_ENC_HALT_WORD_EN appends a halt word at close.
// Revision : 1.0
// ============================================================================
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_finish,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [3:0]        i_req_op,
    input  logic [4:0]        i_req_rs,
    input  logic [4:0]        i_req_rt,
    input  logic [4:0]        i_req_rd,
    input  logic [15:0]       i_req_imm,
    output logic              o_imem_we,
    input  logic              i_imem_ready,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W:0]   o_words_written,
    output logic              o_err_illegal,
    output logic              o_err_overflow
);

    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_words_one = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   c_max_words = (ADDR_W+1)'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_WRITE  = 3'd2,
        S_TERM   = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_words;
    logic [31:0]       r_wdata;
    logic              r_err_ill, r_err_ovf, r_fin_pend, r_halting;

    logic [31:0] w_enc_word;
    logic        w_illegal, w_full;
    logic        w_req_ready, w_we, w_busy, w_done;
    logic        w_open, w_accept, w_commit, w_set_ill, w_set_ovf, w_load_halt;

    mips_instr_field_pack u_pack (
        .i_op      (i_req_op),
        .i_rs      (i_req_rs),
        .i_rt      (i_req_rt),
        .i_rd      (i_req_rd),
        .i_imm     (i_req_imm),
        .o_word    (w_enc_word),
        .o_illegal (w_illegal)
    );

    assign w_full = (r_words == c_max_words);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_we        = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_open      = 1'b0;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        w_set_ill   = 1'b0;
        w_set_ovf   = 1'b0;
        w_load_halt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (i_start) begin
                    w_open      = 1'b1;
                    w_state_nxt = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                // finish takes priority, so ready drops to keep the handshake honest
                w_req_ready = !i_finish;
                if (i_finish) begin
                    w_state_nxt = S_TERM;
                end else if (i_req_valid) begin
                    w_set_ill = w_illegal;
                    w_set_ovf = w_full;
                    if (!w_illegal && !w_full) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                w_we = 1'b1;
                if (i_imem_ready) begin
                    w_commit = 1'b1;
                    if (r_halting)                   w_state_nxt = S_DONE;
                    else if (r_fin_pend || i_finish) w_state_nxt = S_TERM;
                    else                             w_state_nxt = S_ACCEPT;
                end
            end
            S_TERM: begin
`ifdef MIPS_INSTR_ENC_HALT_WORD_EN
                if (w_full) begin
                    w_set_ovf   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_load_halt = 1'b1;
                    w_state_nxt = S_WRITE;
                end
`else
                w_state_nxt = S_DONE;
`endif
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_words    <= '0;
            r_wdata    <= '0;
            r_err_ill  <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_fin_pend <= 1'b0;
            r_halting  <= 1'b0;
        end else begin
            if (w_open) begin
                r_addr     <= i_base_addr;
                r_words    <= '0;
                r_err_ill  <= 1'b0;
                r_err_ovf  <= 1'b0;
                r_fin_pend <= 1'b0;
                r_halting  <= 1'b0;
            end
            if (w_set_ill) r_err_ill <= 1'b1;
            if (w_set_ovf) r_err_ovf <= 1'b1;
            if (w_accept)  r_wdata   <= w_enc_word;
            if (w_load_halt) begin
                r_wdata   <= HALT_WORD;
                r_halting <= 1'b1;
            end
            if (r_state == S_WRITE && i_finish) r_fin_pend <= 1'b1;
            if (w_commit) begin
                r_addr     <= r_addr + c_addr_one;
                r_words    <= r_words + c_words_one;
                r_fin_pend <= 1'b0;
                r_halting  <= 1'b0;
            end
        end
    end

    assign o_req_ready     = w_req_ready;
    assign o_imem_we       = w_we;
    assign o_imem_addr     = r_addr;
    assign o_imem_wdata    = r_wdata;
    assign o_busy          = w_busy;
    assign o_done          = w_done;
    assign o_words_written = r_words;
    assign o_err_illegal   = r_err_ill;
    assign o_err_overflow  = r_err_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_instr_encoder
// Brief    : Directed self-checking bench for mips_instr_encoder.
// Revision : 1.0
// ============================================================================
module tb_mips_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, finish, req_valid, imem_ready;
    logic [9:0]  base_addr;
    logic [3:0]  req_op;
    logic [4:0]  req_rs, req_rt, req_rd;
    logic [15:0] req_imm;
    logic        sel;

    logic        rdy1, we1, busy1, done1, ill1, ovf1;
    logic [9:0]  addr1;
    logic [31:0] wdata1;
    logic [10:0] words1;
    logic        rdy2, we2, busy2, done2, ill2, ovf2;
    logic [9:0]  addr2;
    logic [31:0] wdata2;
    logic [10:0] words2;
    logic        ready_sel, done_sel, busy_sel;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_instr_encoder #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
        .i_finish(finish), .i_req_valid(req_valid), .o_req_ready(rdy1),
        .i_req_op(req_op), .i_req_rs(req_rs), .i_req_rt(req_rt), .i_req_rd(req_rd),
        .i_req_imm(req_imm), .o_imem_we(we1), .i_imem_ready(imem_ready),
        .o_imem_addr(addr1), .o_imem_wdata(wdata1), .o_busy(busy1), .o_done(done1),
        .o_words_written(words1), .o_err_illegal(ill1), .o_err_overflow(ovf1)
    );

    mips_instr_encoder #(.ADDR_W(10), .MAX_WORDS(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
        .i_finish(finish), .i_req_valid(req_valid), .o_req_ready(rdy2),
        .i_req_op(req_op), .i_req_rs(req_rs), .i_req_rt(req_rt), .i_req_rd(req_rd),
        .i_req_imm(req_imm), .o_imem_we(we2), .i_imem_ready(imem_ready),
        .o_imem_addr(addr2), .o_imem_wdata(wdata2), .o_busy(busy2), .o_done(done2),
        .o_words_written(words2), .o_err_illegal(ill2), .o_err_overflow(ovf2)
    );

    assign ready_sel = sel ? rdy2  : rdy1;
    assign done_sel  = sel ? done2 : done1;
    assign busy_sel  = sel ? busy2 : busy1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_session(input logic [9:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm);
        int n = 0;
        req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm;
        req_valid = 1'b1;
        while (!ready_sel && n < 20) begin
            tick();
            n++;
        end
        if (!ready_sel) check_eq("send_timeout", 32'd0, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // Expects the write phase to be showing now; imem_ready must be high.
    task automatic expect_write(input string tag, input logic [9:0] a, input logic [31:0] w);
        check_eq({tag, "_we"},    {31'd0, we1}, 32'd1);
        check_eq({tag, "_addr"},  {22'd0, addr1}, {22'd0, a});
        check_eq({tag, "_wdata"}, wdata1, w);
        tick();
    endtask

    task automatic wait_done(input string tag);
        int  n    = 0;
        logic seen = 1'b0;
        while (!seen && n < 10) begin
            if (done_sel) seen = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        check_eq({tag, "_done"}, {31'd0, seen}, 32'd1);
        tick();
        check_eq({tag, "_idle"}, {30'd0, done_sel, busy_sel}, 32'd0);
    endtask

    task automatic close_session(input string tag);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        wait_done(tag);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; finish = 1'b0; req_valid = 1'b0; imem_ready = 1'b1;
        base_addr = '0; req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0;
        sel = 1'b0;
        tick(); tick();
        check_eq("reset_outs", {5'd0, rdy1, we1, busy1, done1, ill1, ovf1, words1, addr1}, 32'd0);
        check_eq("reset_wdata", wdata1, 32'd0);
        rst_n = 1'b1;
        tick();

        // ADD with immediate memory acceptance
        open_session(10'h010);
        check_eq("open_ready", {30'd0, rdy1, busy1}, 32'd3);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0);
        check_eq("add_ready_low", {31'd0, rdy1}, 32'd0);
        expect_write("add", 10'h010, 32'h0022_1820);
        check_eq("add_words", {21'd0, words1}, 32'd1);
        close_session("s1");

        // LW stalled by imem for 3 cycles, then SW
        open_session(10'h010);
        imem_ready = 1'b0;
        send(4'd5, 5'd1, 5'd2, 5'd0, 16'd4);
        for (int i = 0; i < 3; i++) begin
            check_eq("lw_hold_we",    {30'd0, we1, rdy1}, 32'd2);
            check_eq("lw_hold_addr",  {22'd0, addr1}, 32'h010);
            check_eq("lw_hold_wdata", wdata1, 32'h8C22_0004);
            tick();
        end
        imem_ready = 1'b1;
        check_eq("lw_last_ready", {31'd0, rdy1}, 32'd0);
        expect_write("lw", 10'h010, 32'h8C22_0004);
        send(4'd6, 5'd1, 5'd2, 5'd0, 16'd8);
        expect_write("sw", 10'h011, 32'hAC22_0008);

        // BEQ / ADDI / SUB at consecutive addresses
        send(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF);
        expect_write("beq", 10'h012, 32'h1022_FFFF);
        send(4'd8, 5'd0, 5'd2, 5'd9, 16'd5);
        expect_write("addi", 10'h013, 32'h2002_0005);
        send(4'd1, 5'd1, 5'd2, 5'd4, 16'd0);
        expect_write("sub", 10'h014, 32'h0022_2022);
        check_eq("words_5", {21'd0, words1}, 32'd5);

        // Illegal op is consumed, flag sticks; following OR still writes
        send(4'd12, 5'd1, 5'd2, 5'd3, 16'd0);
        check_eq("ill_state", {29'd0, we1, ill1, rdy1}, 32'd3);
        send(4'd3, 5'd1, 5'd2, 5'd3, 16'd0);
        expect_write("or", 10'h015, 32'h0022_1825);
        check_eq("ill_sticky", {30'd0, ill1, ovf1}, 32'd2);
        check_eq("words_6", {21'd0, words1}, 32'd6);
        close_session("s2");
        check_eq("ill_until_start", {31'd0, ill1}, 32'd1);
        open_session(10'h100);
        check_eq("ill_cleared", {20'd0, ill1, words1}, 32'd0);
        close_session("s3");

        // Overflow on the MAX_WORDS=2 instance; halt word (if enabled) skipped
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sel = 1'b1;
        open_session(10'h020);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0);
        tick();
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0);
        tick();
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0);
        check_eq("ovf_nowrite", {31'd0, we2}, 32'd0);
        check_eq("ovf_words", {21'd0, words2}, 32'd2);
        check_eq("ovf_addr", {22'd0, addr2}, 32'h022);
        check_eq("ovf_flag", {30'd0, ovf2, ill2}, 32'd2);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check_eq("ovf_term", {30'd0, we2, busy2}, 32'd1);
        tick();
        check_eq("ovf_done", {29'd0, we2, done2, ovf2}, 32'd3);
        tick();
        check_eq("ovf_idle", {30'd0, done2, busy2}, 32'd0);
        sel = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // finish during a stalled write is latched until the write lands
        open_session(10'h040);
        imem_ready = 1'b0;
        send(4'd2, 5'd5, 5'd6, 5'd7, 16'd0);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check_eq("latch_hold", {30'd0, we1, rdy1}, 32'd2);
        imem_ready = 1'b1;
        check_eq("and_wdata", wdata1, 32'h00A6_3824);
        tick();
        check_eq("latch_term", {29'd0, we1, rdy1, busy1}, 32'd1);
        check_eq("latch_words", {21'd0, words1}, 32'd1);
`ifdef MIPS_INSTR_ENC_HALT_WORD_EN
        tick();
        expect_write("halt_after_latch", 10'h041, 32'h1000_FFFF);
`endif
        wait_done("s4");

`ifdef MIPS_INSTR_ENC_HALT_WORD_EN
        // Halt word appended at close
        open_session(10'h030);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0);
        expect_write("h_add", 10'h030, 32'h0022_1820);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check_eq("h_term", {31'd0, we1}, 32'd0);
        tick();
        expect_write("h_halt", 10'h031, 32'h1000_FFFF);
        check_eq("h_done", {31'd0, done1}, 32'd1);
        check_eq("h_words", {21'd0, words1}, 32'd2);
        tick();
        // Reset during the halt write
        open_session(10'h050);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        imem_ready = 1'b0;
        tick();
        check_eq("h_stall_we", {31'd0, we1}, 32'd1);
        rst_n = 1'b0;
        tick();
        check_eq("h_rst_outs", {5'd0, rdy1, we1, busy1, done1, ill1, ovf1, words1, addr1}, 32'd0);
        check_eq("h_rst_wdata", wdata1, 32'd0);
        rst_n = 1'b1;
        imem_ready = 1'b1;
        tick();
`endif

        // Reset mid-write drops the pending word
        open_session(10'h060);
        imem_ready = 1'b0;
        send(4'd4, 5'd1, 5'd2, 5'd3, 16'd0);
        check_eq("slt_wdata", wdata1, 32'h0022_182A);
        rst_n = 1'b0;
        tick();
        check_eq("rst_mid_outs", {5'd0, rdy1, we1, busy1, done1, ill1, ovf1, words1, addr1}, 32'd0);
        check_eq("rst_mid_wdata", wdata1, 32'd0);
        rst_n = 1'b1;
        imem_ready = 1'b1;
        tick();
        check_eq("post_rst_idle", {30'd0, we1, busy1}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Inverse of the single-cycle control decoder: accepts symbolic instruction requests (op class plus register and immediate fields) and encodes them into 32-bit MIPS words.
- Encoded words are written sequentially into instruction memory through a ready-gated write port.
- Used by the bring-up loader and self-test sequencer to fill imem before the core leaves reset.
- Opcode and funct encodings match exactly the set the decoder recognises.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- MAX_WORDS, 1024, words writable per session; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; opens a session at base_addr.
- base_addr  in  ADDR_W  first word address of the session.
- finish  in  1  one-cycle pulse; closes the session.
- req_valid  in  1  request present.
- req_ready  out  1  encoder can accept a request.
- req_op  in  4  0=ADD, 1=SUB, 2=AND, 3=OR, 4=SLT, 5=LW, 6=SW, 7=BEQ, 8=ADDI; 9-15 illegal.
- req_rs, req_rt, req_rd  in  5 each  register fields.
- req_imm  in  16  immediate / branch offset.
- imem_we  out  1  write strobe, held until accepted.
- imem_ready  in  1  memory accepts the write this cycle.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  encoded word.
- busy  out  1  session open or draining.
- done  out  1  one-cycle pulse at session close.
- words_written  out  ADDR_W+1  words committed this session.
- err_illegal  out  1  sticky; an illegal op was seen.
- err_overflow  out  1  sticky; a request arrived with MAX_WORDS already written.

Behaviour:
- Reset (rst_n low at a clk edge) forces state IDLE and clears all outputs to 0, including both error flags and words_written. Reset mid-write drops the pending word.
- FSM states: IDLE, ACCEPT, WRITE, TERM, DONE.
- IDLE:
  - start loads addr := base_addr, clears words_written and both error flags, then goes to ACCEPT.
  - finish in IDLE is ignored.
- ACCEPT:
  - req_ready = 1.
  - On req_valid & req_ready, the encoded word is registered and the FSM goes to WRITE. imem_we rises the next cycle, giving 1-cycle latency from accept to strobe.
  - On an illegal op: the request is consumed, err_illegal is set, nothing is written, and the FSM stays in ACCEPT.
  - With words_written == MAX_WORDS: the request is consumed, err_overflow is set, nothing is written.
- WRITE:
  - imem_we = 1, with addr/wdata held stable until imem_ready.
  - On imem_we & imem_ready: addr increments (wraps modulo 2^ADDR_W), words_written increments, and the FSM returns to ACCEPT.
  - req_ready = 0 in this state, so at most one word is in flight.
- finish handling:
  - finish in ACCEPT goes to TERM.
  - finish while in WRITE is latched; TERM is entered after the in-flight write completes.
  - If finish and req_valid coincide in ACCEPT, finish wins and the request is not accepted.
- TERM: goes straight to DONE, or performs the halt-word write described under Optional Feature.
- DONE: done pulses for one cycle, then the FSM returns to IDLE. busy = 1 in every state except IDLE.
- start outside IDLE is ignored.
- Encoding, with fields placed MSB-first:
  - R-type: op 000000 | rs | rt | rd | shamt 00000 | funct.
  - Funct codes: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - I-type: op | rs | rt | imm.
  - Opcodes: LW 100011, SW 101011, BEQ 000100, ADDI 001000.
  - req_rd is ignored for I-type ops.

Optional Feature:
- Macro: MIPS_INSTR_ENC_HALT_WORD_EN.
- Defined: TERM writes the self-loop halt word 0x1000FFFF (beq $0,$0,-1) at the current addr, using the normal WRITE handshake and counting toward words_written. If MAX_WORDS has already been reached, err_overflow is set and the halt word is skipped.
- Undefined: TERM goes directly to DONE.

Decomposition:
- Shared package mips_isa_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI;
  - funct constants FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT;
  - req_op enum type;
  - HALT_WORD constant.
- The decoder side imports the same package.
- One sub-module, mips_instr_field_pack: a purely combinational op plus fields to 32-bit word and illegal flag. The FSM and counters live in the top module.

Test Plan:
- start base_addr=0x010; ADD rs=1 rt=2 rd=3 with imem_ready=1 → imem_we at addr 0x010, wdata 0x00221820, words_written=1.
- LW rs=1 rt=2 imm=4, then SW same regs imm=8, with imem_ready low for 3 cycles on the first write → 0x8C220004 at 0x010 held stable for 4 cycles, then 0xAC220008 at 0x011; req_ready low throughout WRITE.
- BEQ rs=1 rt=2 imm=0xFFFF, ADDI rs=0 rt=2 imm=5, SUB rs=1 rt=2 rd=4 → 0x1022FFFF, 0x20020005, 0x00222022 at consecutive addresses.
- req_op=12 → request consumed, no imem_we, err_illegal=1 until the next start; a following OR rs=1 rt=2 rd=3 still writes 0x00221825.
- MAX_WORDS=2: three ADD requests → two writes, err_overflow=1; finish → done pulse. With MIPS_INSTR_ENC_HALT_WORD_EN, the halt word is skipped.
- With MIPS_INSTR_ENC_HALT_WORD_EN: one ADD then finish → second write 0x1000FFFF at base+1, words_written=2, done one cycle after the write is accepted; rst_n low during the halt write → all outputs 0, state IDLE.
